axilite_slave_gen2: RTL and testbench
=====================================

// Module: axilite_slave_gen2
// PURPOSE
//  Parametrised AXI4-Lite slave; successor to the first-generation AXI-Lite slave.
//  - Adds full B channel and BRESP/RRESP.
//  - Adds RREADY/BREADY back-pressure and an address-window check.
//  - Generic address/data width.
//  - Bridges AXI-Lite to the block's bk_* start/done backend request ports (one write, one read channel).
// PARAMETERS
//  ADDR_W     32           AXI/backend address width
//  DATA_W     32           data width (32 or 64); STRB_W = DATA_W/8
//  BASE_ADDR  'h3000_0000  first byte address of the decoded window
//  WIN_SIZE   'h1000       window size in bytes, power of 2
//  TIMEOUT    255          backend timeout in cycles (used only with AXIL_BK_TIMEOUT_EN)
// PORTS
//  axi_aclk     in   1        clock
//  axi_areset   in   1        async reset, active-high
//  axi_awvalid  in   1        / axi_awready out 1 / axi_awaddr in ADDR_W
//  axi_wvalid   in   1        / axi_wready out 1 / axi_wdata in DATA_W / axi_wstrb in STRB_W
//  axi_bvalid   out  1        / axi_bready in 1 / axi_bresp out 2
//  axi_arvalid  in   1        / axi_arready out 1 / axi_araddr in ADDR_W
//  axi_rvalid   out  1        / axi_rready in 1 / axi_rdata out DATA_W / axi_rresp out 2
//  bk_wstart    out  1        backend write request, level, held until bk_wdone
//  bk_waddr     out  ADDR_W   offset address (axi addr - BASE_ADDR)
//  bk_wdata     out  DATA_W   / bk_wstrb out STRB_W: write payload
//  bk_wdone     in   1        backend write complete (single-cycle pulse)
//  bk_rstart    out  1        / bk_raddr out ADDR_W: backend read request, level
//  bk_rdata     in   DATA_W   / bk_rdone in 1: read data, valid with bk_rdone
// BEHAVIOUR
//  Reset: all valid/ready/start outputs 0; resp 2'b00; rdata, bk_* data/addr 0. FSMs go to IDLE.
//  Write FSM W_IDLE -> W_BK -> W_RESP -> W_IDLE.
//   - W_IDLE: awready = !aw_held, wready = !w_held.
//   - AW and W are captured independently, in any order or the same cycle.
//   - Leave W_IDLE when both are held.
//   - In range: enter W_BK, bk_wstart=1 with offset/data/strb stable.
//   - Out of range: skip W_BK and go straight to W_RESP with bresp=DECERR (2'b11).
//   - W_BK: on bk_wdone go to W_RESP, bresp=OKAY, bk_wstart drops the same edge.
//   - W_RESP: bvalid=1 and held with bresp stable until bready. Then W_IDLE and clear holds.
//   - Latency: AW+W accepted in cycle N, bk_wstart in N+1; wdone in N+1 gives bvalid in N+2.
//  Read FSM R_IDLE -> R_BK -> R_DATA -> R_IDLE.
//   - arready=1 only in R_IDLE.
//   - In range: enter R_BK, bk_rstart=1. Out of range: go to R_DATA with rdata=0, rresp=DECERR.
//   - R_BK: on bk_rdone capture bk_rdata into axi_rdata, then R_DATA.
//   - R_DATA: rvalid held, rdata/rresp stable, until rready.
//  Read and write paths are fully independent; same-cycle AW/W/AR all accepted. No read/write ordering.
//  Range check: BASE_ADDR <= addr < BASE_ADDR+WIN_SIZE; the offset is the low log2(WIN_SIZE) bits.
//  bk_*done is ignored while the matching start is low.
//  Reset mid-transaction: abort immediately. Starts drop asynchronously, no response issued.
// CONFIGURATION
//  AXIL_BK_TIMEOUT_EN defined:
//   - An 8..16-bit counter runs in W_BK/R_BK.
//   - After TIMEOUT cycles without done: drop start and respond SLVERR (2'b10), rdata=0.
//   - A done arriving in the same cycle as expiry wins (OKAY).
//  Not defined: W_BK/R_BK wait indefinitely; TIMEOUT is unused.
// STRUCTURE
//  Package axilite_pkg: resp_t enum (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3), wr_state_t, rd_state_t.
//  Sub-module axilite_gen2_addr_dec (combinational range check + offset), instanced twice (AW, AR).
//  The FSMs stay in the top module.
// TESTING
//  1. AW 0x3000_0010 + W 0xDEAD_BEEF strb 0xF same cycle, wdone 1 cycle later
//     -> bk_waddr 0x010, bk_wdata 0xDEADBEEF, bvalid OKAY 2 cycles after accept.
//  2. W before AW (3 cycles apart)
//     -> no bk_wstart until AW accepted; wready low while W is held.
//  3. AR 0x3000_0FFC, bk_rdone with 0x1234_5678 after 5 cycles, rready low 4 cycles
//     -> rvalid/rdata held stable, rresp OKAY.
//  4. AW 0x3000_1000 (out of range)
//     -> no bk_wstart, bresp DECERR. AR 0x2FFF_FFFC -> rdata 0, rresp DECERR.
//  5. Simultaneous write and read to in-range addrs
//     -> bk_wstart and bk_rstart both assert in the same cycle; both complete.
//  6. AXIL_BK_TIMEOUT_EN, TIMEOUT=8, no wdone
//     -> bvalid SLVERR at 8 cycles. Also: assert reset during W_BK -> bk_wstart 0, no bvalid.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared types for the gen2 AXI4-Lite slave: response codes and FSM state encodings.
package axilite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'b00,
        W_BK   = 2'b01,
        W_RESP = 2'b10
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'b00,
        R_BK   = 2'b01,
        R_DATA = 2'b10
    } rd_state_t;

endpackage

// File: rtl/axilite_gen2_addr_dec.sv
// Combinational window decode: flags addresses inside [BASE_ADDR, BASE_ADDR+WIN_SIZE)
// and returns the in-window byte offset.
module axilite_gen2_addr_dec #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h3000_0000,
    parameter int                WIN_SIZE  = 32'h0000_1000
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [ADDR_W-1:0] offset
);

    // One extra bit keeps the upper bound from wrapping when the window ends at the top of memory.
    localparam logic [ADDR_W:0]   LO_BOUND = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0]   HI_BOUND = LO_BOUND + (ADDR_W+1)'(WIN_SIZE);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(WIN_SIZE - 1);

    // Range compare and offset extraction.
    always_comb begin
        hit    = ({1'b0, addr} >= LO_BOUND) && ({1'b0, addr} < HI_BOUND);
        offset = addr & OFF_MASK;
    end

endmodule

// File: rtl/axilite_slave_gen2.sv
// AXI4-Lite slave bridging to bk_* start/done backend ports, with independent write and read FSMs.
// Optional backend timeout (SLVERR on expiry) is enabled by defining AXIL_BK_TIMEOUT_EN.
module axilite_slave_gen2
    import axilite_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h3000_0000,
    parameter int                WIN_SIZE  = 32'h0000_1000,
    parameter int                TIMEOUT   = 255,
    localparam int               STRB_W    = DATA_W / 8
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    input  logic [DATA_W-1:0] axi_wdata,
    input  logic [STRB_W-1:0] axi_wstrb,
    output logic              axi_bvalid,
    input  logic              axi_bready,
    output logic [1:0]        axi_bresp,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    input  logic [ADDR_W-1:0] axi_araddr,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    output logic [DATA_W-1:0] axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              bk_wstart,
    output logic [ADDR_W-1:0] bk_waddr,
    output logic [DATA_W-1:0] bk_wdata,
    output logic [STRB_W-1:0] bk_wstrb,
    input  logic              bk_wdone,
    output logic              bk_rstart,
    output logic [ADDR_W-1:0] bk_raddr,
    input  logic [DATA_W-1:0] bk_rdata,
    input  logic              bk_rdone
);

    wr_state_t         w_state_q, w_state_d;
    rd_state_t         r_state_q, r_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d, aw_hit_q, aw_hit_d;
    logic [ADDR_W-1:0] aw_off_q, aw_off_d, raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic              awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic              bk_wstart_q, bk_wstart_d, bk_rstart_q, bk_rstart_d;
    resp_t             bresp_q, bresp_d, rresp_q, rresp_d;
    logic              aw_dec_hit_s, ar_dec_hit_s, aw_fire_s, w_fire_s, ar_fire_s;
    logic [ADDR_W-1:0] aw_dec_off_s, ar_dec_off_s;
    logic              w_expire_s, r_expire_s;

    axilite_gen2_addr_dec #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .WIN_SIZE(WIN_SIZE)) u_aw_dec (
        .addr(axi_awaddr), .hit(aw_dec_hit_s), .offset(aw_dec_off_s));
    axilite_gen2_addr_dec #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .WIN_SIZE(WIN_SIZE)) u_ar_dec (
        .addr(axi_araddr), .hit(ar_dec_hit_s), .offset(ar_dec_off_s));

    assign aw_fire_s = axi_awvalid && awready_q;
    assign w_fire_s  = axi_wvalid && wready_q;
    assign ar_fire_s = axi_arvalid && arready_q;

`ifdef AXIL_BK_TIMEOUT_EN
    logic [15:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d;

    // Per-path wait counters; they restart from zero on every entry into the backend state.
    always_comb begin
        wcnt_d     = (w_state_q == W_BK) ? wcnt_q + 16'd1 : 16'd0;
        rcnt_d     = (r_state_q == R_BK) ? rcnt_q + 16'd1 : 16'd0;
        w_expire_s = (w_state_q == W_BK) && (wcnt_q == 16'(TIMEOUT - 1));
        r_expire_s = (r_state_q == R_BK) && (rcnt_q == 16'(TIMEOUT - 1));
    end

    // Timeout counter registers.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wcnt_q <= 16'd0;
            rcnt_q <= 16'd0;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
        end
    end
`else
    logic unused_timeout_s;
    assign w_expire_s       = 1'b0;
    assign r_expire_s       = 1'b0;
    assign unused_timeout_s = (TIMEOUT != 0);
`endif

    // Write path: AW and W are latched independently; the transaction launches once both are held.
    always_comb begin
        w_state_d   = w_state_q;
        aw_held_d   = aw_held_q | aw_fire_s;
        w_held_d    = w_held_q | w_fire_s;
        aw_off_d    = aw_fire_s ? aw_dec_off_s : aw_off_q;
        aw_hit_d    = aw_fire_s ? aw_dec_hit_s : aw_hit_q;
        wdata_d     = w_fire_s ? axi_wdata : wdata_q;
        wstrb_d     = w_fire_s ? axi_wstrb : wstrb_q;
        bk_wstart_d = bk_wstart_q;
        bvalid_d    = bvalid_q;
        bresp_d     = bresp_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_held_d && w_held_d) begin
                    if (aw_hit_d) begin
                        w_state_d   = W_BK;
                        bk_wstart_d = 1'b1;
                    end else begin
                        w_state_d = W_RESP;
                        bvalid_d  = 1'b1;
                        bresp_d   = DECERR;
                    end
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_BK: begin
                if (bk_wdone) begin
                    w_state_d   = W_RESP;
                    bk_wstart_d = 1'b0;
                    bvalid_d    = 1'b1;
                    bresp_d     = OKAY;
                end else if (w_expire_s) begin
                    w_state_d   = W_RESP;
                    bk_wstart_d = 1'b0;
                    bvalid_d    = 1'b1;
                    bresp_d     = SLVERR;
                end else begin
                    bk_wstart_d = 1'b1;
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    w_state_d = W_IDLE;
                    bvalid_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read path: one outstanding read, response held until rready.
    always_comb begin
        r_state_d   = r_state_q;
        raddr_d     = raddr_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rvalid_d    = rvalid_q;
        bk_rstart_d = bk_rstart_q;
        case (r_state_q)
            R_IDLE: begin
                if (ar_fire_s && ar_dec_hit_s) begin
                    r_state_d   = R_BK;
                    raddr_d     = ar_dec_off_s;
                    bk_rstart_d = 1'b1;
                end else if (ar_fire_s) begin
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                    rdata_d   = {DATA_W{1'b0}};
                    rresp_d   = DECERR;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_BK: begin
                if (bk_rdone) begin
                    r_state_d   = R_DATA;
                    bk_rstart_d = 1'b0;
                    rvalid_d    = 1'b1;
                    rdata_d     = bk_rdata;
                    rresp_d     = OKAY;
                end else if (r_expire_s) begin
                    r_state_d   = R_DATA;
                    bk_rstart_d = 1'b0;
                    rvalid_d    = 1'b1;
                    rdata_d     = {DATA_W{1'b0}};
                    rresp_d     = SLVERR;
                end else begin
                    bk_rstart_d = 1'b1;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    r_state_d = R_IDLE;
                    rvalid_d  = 1'b0;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    // State and registered-output flops; reset aborts any transaction in flight.
    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            aw_held_q   <= 1'b0;
            w_held_q    <= 1'b0;
            aw_hit_q    <= 1'b0;
            aw_off_q    <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            wstrb_q     <= {STRB_W{1'b0}};
            raddr_q     <= {ADDR_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            arready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            bk_wstart_q <= 1'b0;
            bk_rstart_q <= 1'b0;
            bresp_q     <= OKAY;
            rresp_q     <= OKAY;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            aw_held_q   <= aw_held_d;
            w_held_q    <= w_held_d;
            aw_hit_q    <= aw_hit_d;
            aw_off_q    <= aw_off_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            raddr_q     <= raddr_d;
            rdata_q     <= rdata_d;
            awready_q   <= awready_d;
            wready_q    <= wready_d;
            arready_q   <= arready_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            bk_wstart_q <= bk_wstart_d;
            bk_rstart_q <= bk_rstart_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
        end
    end

    assign axi_awready = awready_q;
    assign axi_wready  = wready_q;
    assign axi_arready = arready_q;
    assign axi_bvalid  = bvalid_q;
    assign axi_bresp   = bresp_q;
    assign axi_rvalid  = rvalid_q;
    assign axi_rdata   = rdata_q;
    assign axi_rresp   = rresp_q;
    assign bk_wstart   = bk_wstart_q;
    assign bk_waddr    = aw_off_q;
    assign bk_wdata    = wdata_q;
    assign bk_wstrb    = wstrb_q;
    assign bk_rstart   = bk_rstart_q;
    assign bk_raddr    = raddr_q;

endmodule

// File: tb/tb_axilite_slave_gen2.sv
// Directed bench for axilite_slave_gen2: hand-computed expectations for write, read,
// back-pressure, decode errors, concurrency and mid-transaction reset.
module tb_axilite_slave_gen2;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [ADDR_W-1:0] awaddr, araddr, bk_waddr, bk_raddr;
    logic [DATA_W-1:0] wdata, rdata, bk_wdata, bk_rdata;
    logic [STRB_W-1:0] wstrb, bk_wstrb;
    logic [1:0]        bresp, rresp;
    logic              bk_wstart, bk_wdone, bk_rstart, bk_rdone;

    int n_cmp = 0;
    int n_err = 0;

    axilite_slave_gen2 #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BASE_ADDR(32'h3000_0000),
        .WIN_SIZE(32'h0000_1000), .TIMEOUT(8)
    ) dut (
        .axi_aclk(clk), .axi_areset(rst),
        .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr),
        .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
        .axi_bvalid(bvalid), .axi_bready(bready), .axi_bresp(bresp),
        .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr),
        .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata), .axi_rresp(rresp),
        .bk_wstart(bk_wstart), .bk_waddr(bk_waddr), .bk_wdata(bk_wdata), .bk_wstrb(bk_wstrb),
        .bk_wdone(bk_wdone), .bk_rstart(bk_rstart), .bk_raddr(bk_raddr),
        .bk_rdata(bk_rdata), .bk_rdone(bk_rdone)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        awvalid = 1'b0; awaddr = 32'h0; wvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
        bready = 1'b0; arvalid = 1'b0; araddr = 32'h0; rready = 1'b0;
        bk_wdone = 1'b0; bk_rdone = 1'b0; bk_rdata = 32'h0;
        repeat (3) tick();
        check_val("rst_awready", 64'(awready), 64'd0);
        check_val("rst_arready", 64'(arready), 64'd0);
        check_val("rst_bvalid", 64'(bvalid), 64'd0);
        check_val("rst_rvalid", 64'(rvalid), 64'd0);
        check_val("rst_wstart", 64'(bk_wstart), 64'd0);
        check_val("rst_rdata", 64'(rdata), 64'd0);
        rst = 1'b0;
        tick();
        check_val("idle_awready", 64'(awready), 64'd1);
        check_val("idle_arready", 64'(arready), 64'd1);

        // 1: AW + W in the same cycle, wdone one cycle later
        awvalid = 1'b1; awaddr = 32'h3000_0010; wvalid = 1'b1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("t1_wstart", 64'(bk_wstart), 64'd1);
        check_val("t1_waddr", 64'(bk_waddr), 64'h010);
        check_val("t1_wdata", 64'(bk_wdata), 64'hDEAD_BEEF);
        check_val("t1_wstrb", 64'(bk_wstrb), 64'hF);
        check_val("t1_awready", 64'(awready), 64'd0);
        check_val("t1_bvalid_early", 64'(bvalid), 64'd0);
        bk_wdone = 1'b1;
        tick();
        bk_wdone = 1'b0;
        check_val("t1_bvalid", 64'(bvalid), 64'd1);
        check_val("t1_bresp", 64'(bresp), 64'd0);
        check_val("t1_wstart_drop", 64'(bk_wstart), 64'd0);
        tick();
        check_val("t1_bvalid_hold", 64'(bvalid), 64'd1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_val("t1_bvalid_clr", 64'(bvalid), 64'd0);
        check_val("t1_awready_back", 64'(awready), 64'd1);

        // 2: W three cycles before AW
        wvalid = 1'b1; wdata = 32'hCAFE_0001; wstrb = 4'h3;
        tick();
        wvalid = 1'b0;
        check_val("t2_wready_low", 64'(wready), 64'd0);
        tick(); tick();
        check_val("t2_no_wstart", 64'(bk_wstart), 64'd0);
        check_val("t2_wready_held", 64'(wready), 64'd0);
        awvalid = 1'b1; awaddr = 32'h3000_0020;
        tick();
        awvalid = 1'b0;
        check_val("t2_wstart", 64'(bk_wstart), 64'd1);
        check_val("t2_waddr", 64'(bk_waddr), 64'h020);
        check_val("t2_wdata", 64'(bk_wdata), 64'hCAFE_0001);
        check_val("t2_wstrb", 64'(bk_wstrb), 64'h3);
        bk_wdone = 1'b1; bready = 1'b1;
        tick();
        bk_wdone = 1'b0;
        check_val("t2_bvalid", 64'(bvalid), 64'd1);
        check_val("t2_bresp", 64'(bresp), 64'd0);
        tick();
        bready = 1'b0;
        check_val("t2_bvalid_clr", 64'(bvalid), 64'd0);

        // 3: read at the last word of the window, slow backend, rready held low
        arvalid = 1'b1; araddr = 32'h3000_0FFC;
        tick();
        arvalid = 1'b0;
        check_val("t3_rstart", 64'(bk_rstart), 64'd1);
        check_val("t3_raddr", 64'(bk_raddr), 64'hFFC);
        check_val("t3_arready", 64'(arready), 64'd0);
        repeat (4) tick();
        check_val("t3_rvalid_early", 64'(rvalid), 64'd0);
        bk_rdone = 1'b1; bk_rdata = 32'h1234_5678;
        tick();
        bk_rdone = 1'b0; bk_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check_val("t3_rvalid", 64'(rvalid), 64'd1);
            check_val("t3_rdata", 64'(rdata), 64'h1234_5678);
            check_val("t3_rresp", 64'(rresp), 64'd0);
            tick();
        end
        check_val("t3_rstart_drop", 64'(bk_rstart), 64'd0);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_val("t3_rvalid_clr", 64'(rvalid), 64'd0);
        check_val("t3_arready_back", 64'(arready), 64'd1);

        // 4: decode errors just past the top and just below the base
        awvalid = 1'b1; awaddr = 32'h3000_1000; wvalid = 1'b1; wdata = 32'h0000_0001; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_val("t4_no_wstart", 64'(bk_wstart), 64'd0);
        check_val("t4_bvalid", 64'(bvalid), 64'd1);
        check_val("t4_bresp", 64'(bresp), 64'd3);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        arvalid = 1'b1; araddr = 32'h2FFF_FFFC;
        tick();
        arvalid = 1'b0;
        check_val("t4_no_rstart", 64'(bk_rstart), 64'd0);
        check_val("t4_rvalid", 64'(rvalid), 64'd1);
        check_val("t4_rdata", 64'(rdata), 64'd0);
        check_val("t4_rresp", 64'(rresp), 64'd3);
        rready = 1'b1;
        tick();
        rready = 1'b0;

        // 5: simultaneous in-range write and read
        awvalid = 1'b1; awaddr = 32'h3000_0100; wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hC;
        arvalid = 1'b1; araddr = 32'h3000_0200;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check_val("t5_wstart", 64'(bk_wstart), 64'd1);
        check_val("t5_rstart", 64'(bk_rstart), 64'd1);
        check_val("t5_raddr", 64'(bk_raddr), 64'h200);
        bk_wdone = 1'b1; bk_rdone = 1'b1; bk_rdata = 32'hA5A5_0000;
        tick();
        bk_wdone = 1'b0; bk_rdone = 1'b0;
        check_val("t5_bvalid", 64'(bvalid), 64'd1);
        check_val("t5_rvalid", 64'(rvalid), 64'd1);
        check_val("t5_rdata", 64'(rdata), 64'hA5A5_0000);
        bready = 1'b1; rready = 1'b1;
        tick();
        bready = 1'b0; rready = 1'b0;
        check_val("t5_bvalid_clr", 64'(bvalid), 64'd0);
        check_val("t5_rvalid_clr", 64'(rvalid), 64'd0);

        // 6: backend never answers
        awvalid = 1'b1; awaddr = 32'h3000_0040; wvalid = 1'b1; wdata = 32'h0BAD_F00D; wstrb = 4'hF;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
`ifdef AXIL_BK_TIMEOUT_EN
        repeat (7) tick();
        check_val("t6_bvalid_pre", 64'(bvalid), 64'd0);
        check_val("t6_wstart_pre", 64'(bk_wstart), 64'd1);
        tick();
        check_val("t6_bvalid_to", 64'(bvalid), 64'd1);
        check_val("t6_bresp_to", 64'(bresp), 64'd2);
        check_val("t6_wstart_to", 64'(bk_wstart), 64'd0);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
`else
        repeat (20) tick();
        check_val("t6_bvalid_wait", 64'(bvalid), 64'd0);
`endif
        check_val("t6_wstart_busy", 64'(bk_wstart), 64'd1);
        rst = 1'b1;
        #1;
        check_val("t6_rst_wstart", 64'(bk_wstart), 64'd0);
        check_val("t6_rst_bvalid", 64'(bvalid), 64'd0);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check_val("t6_post_bvalid", 64'(bvalid), 64'd0);
        check_val("t6_post_wstart", 64'(bk_wstart), 64'd0);
        check_val("t6_post_awready", 64'(awready), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
